// File: rtl/lab3_cache_mem_arbiter.sv
// lab3_cache_mem_arbiter: round-robin merge of icache/dcache memory requests with in-order response steering
package lab3_mem_pkg;
  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;
  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module lab3_cache_mem_arbiter
  import lab3_mem_pkg::*;
#(
  parameter int p_depth = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_val,
  output logic         req0_rdy,
  input  mem_req_4B_t  req0_msg,
  output logic         resp0_val,
  input  logic         resp0_rdy,
  output mem_resp_4B_t resp0_msg,
  input  logic         req1_val,
  output logic         req1_rdy,
  input  mem_req_4B_t  req1_msg,
  output logic         resp1_val,
  input  logic         resp1_rdy,
  output mem_resp_4B_t resp1_msg,
  output logic         mem_req_val,
  input  logic         mem_req_rdy,
  output mem_req_4B_t  mem_req_msg,
  input  logic         mem_resp_val,
  output logic         mem_resp_rdy,
  input  mem_resp_4B_t mem_resp_msg
);
  localparam int aw = $clog2(p_depth);
  localparam int cw = aw + 1;
  logic               prio, lock, lock_id;
  logic [p_depth-1:0] ids;
  logic [aw-1:0]      head, tail;
  logic [cw-1:0]      count;
  logic               grant, any, open, nonempty, h, push, pop;
  always_comb begin
    any          = lock | req0_val | req1_val;
    grant        = lock ? lock_id : (req0_val & req1_val) ? prio : req1_val;
    open         = (count != cw'(p_depth)) & ~reset;
    mem_req_val  = any & (grant ? req1_val : req0_val) & open;
    mem_req_msg  = !any ? '0 : grant ? req1_msg : req0_msg;
    req0_rdy     = any & ~grant & mem_req_rdy & open;
    req1_rdy     = any & grant & mem_req_rdy & open;
    nonempty     = (count != '0) & ~reset;
    h            = ids[head];
    resp0_val    = nonempty & ~h & mem_resp_val;
    resp1_val    = nonempty & h & mem_resp_val;
    resp0_msg    = (nonempty & ~h) ? mem_resp_msg : '0;
    resp1_msg    = (nonempty & h) ? mem_resp_msg : '0;
    mem_resp_rdy = nonempty & (h ? resp1_rdy : resp0_rdy);
    push         = mem_req_val & mem_req_rdy;
    pop          = mem_resp_val & mem_resp_rdy;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prio    <= 1'b0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      ids     <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        ids[tail] <= grant;
        tail      <= tail + 1'b1;
        prio      <= ~grant;
        lock      <= 1'b0;
      end else if (mem_req_val) begin
        // hold the stalled grant so the memory-side message stays stable
        lock    <= 1'b1;
        lock_id <= grant;
      end
      if (pop) head <= head + 1'b1;
      count <= count + cw'(push) - cw'(pop);
    end
  end
endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// tb_lab3_cache_mem_arbiter: table-driven vectors plus a response scoreboard for the cache/memory arbiter
module tb_lab3_cache_mem_arbiter;
  import lab3_mem_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  mem_req_4B_t  req0_msg, req1_msg, mem_req_msg;
  mem_resp_4B_t resp0_msg, resp1_msg, mem_resp_msg;
  lab3_cache_mem_arbiter #(.p_depth(4)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        port;
    logic [7:0]  opaque;
    logic [31:0] data;
  } exp_t;
  typedef struct packed {
    logic r0v, r1v, mrdy, want, p0rdy, p1rdy;
    logic mrv;
    logic [1:0] src;
    logic q0rdy, q1rdy, mrr, s0v, s1v;
  } vec_t;
  exp_t        sb[$];
  mem_req_4B_t mem_q[$];
  vec_t        vt[18];
  logic        want;
  int          checks = 0;
  int          errors = 0;
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic mem_req_4B_t mk_req(input logic [7:0] op, input logic [31:0] a);
    mem_req_4B_t r;
    r = '0;
    r.opaque = op;
    r.addr = a;
    return r;
  endfunction
  // memory model answers the oldest accepted request; a response with nothing pending is a dummy
  task automatic settle();
    mem_resp_msg = '0;
    mem_resp_val = want;
    if (want && mem_q.size() > 0) begin
      mem_resp_msg.opaque = mem_q[0].opaque;
      mem_resp_msg.data = mem_q[0].addr ^ 32'hdeadaeef;
    end
    #1;
  endtask
  task automatic check_resp(input logic p, input mem_resp_4B_t m);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL resp_unexpected: port %0d got response with no outstanding request", p);
    end else begin
      e = sb.pop_front();
      check("resp_port", 80'(p), 80'(e.port));
      check("resp_opaque", 80'(m.opaque), 80'(e.opaque));
      check("resp_data", 80'(m.data), 80'(e.data));
    end
  endtask
  task automatic commit();
    if (resp0_val && resp0_rdy) check_resp(1'b0, resp0_msg);
    if (resp1_val && resp1_rdy) check_resp(1'b1, resp1_msg);
    if (mem_resp_val && mem_resp_rdy && mem_q.size() > 0) void'(mem_q.pop_front());
    if (mem_req_val && mem_req_rdy) mem_q.push_back(mem_req_msg);
    if (req0_val && req0_rdy) sb.push_back('{1'b0, req0_msg.opaque, req0_msg.addr ^ 32'hdeadaeef});
    if (req1_val && req1_rdy) sb.push_back('{1'b1, req1_msg.opaque, req1_msg.addr ^ 32'hdeadaeef});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    mem_q.delete();
  endtask
  initial begin
    reset = 1'b1;
    {req0_val, req1_val, mem_req_rdy, resp0_rdy, resp1_rdy, want} = '0;
    req0_msg = '0;
    req1_msg = '0;
    mem_resp_val = 1'b0;
    mem_resp_msg = '0;
    repeat (2) @(posedge clk);
    #1;
    {req0_val, req1_val, mem_req_rdy, resp0_rdy, resp1_rdy, want} = '1;
    settle();
    check("rst_mem_req_val", 80'(mem_req_val), 80'(0));
    check("rst_req0_rdy", 80'(req0_rdy), 80'(0));
    check("rst_req1_rdy", 80'(req1_rdy), 80'(0));
    check("rst_mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
    check("rst_resp_vals", 80'({resp0_val, resp1_val}), 80'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    {req1_val, want} = '0;
    req0_msg = mk_req(8'h05, 32'h1000);
    settle();
    check("single_mem_req_val", 80'(mem_req_val), 80'(1));
    check("single_mem_req_msg", 80'(mem_req_msg), 80'(req0_msg));
    commit();
    req0_val = 1'b0;
    want = 1'b1;
    settle();
    check("single_resp0_val", 80'(resp0_val), 80'(1));
    check("single_resp0_data", 80'(resp0_msg.data), 80'(32'hdeadbeef));
    check("single_resp0_opaque", 80'(resp0_msg.opaque), 80'(8'h05));
    check("single_resp1_val", 80'(resp1_val), 80'(0));
    commit();
    do_reset();
    //             r0 r1 mr wt p0 p1   mrv src  q0 q1 mrr s0 s1
    vt[0]  = 14'b1_0_1_0_1_1__1_00__1_0_0_0_0;
    vt[1]  = 14'b1_1_1_0_1_1__1_01__0_1_1_0_0;
    vt[2]  = 14'b1_1_1_1_1_1__1_00__1_0_1_1_0;
    vt[3]  = 14'b0_1_1_0_1_1__1_01__0_1_1_0_0;
    vt[4]  = 14'b0_1_0_0_1_1__1_01__0_0_1_0_0;
    vt[5]  = 14'b1_1_0_0_1_1__1_01__0_0_1_0_0;
    vt[6]  = 14'b1_1_1_1_1_1__1_01__0_1_1_0_1;
    vt[7]  = 14'b1_1_1_0_1_1__1_00__1_0_1_0_0;
    vt[8]  = 14'b1_1_1_0_1_1__0_01__0_0_1_0_0;
    vt[9]  = 14'b1_1_1_1_1_1__0_01__0_0_1_1_0;
    vt[10] = 14'b1_1_1_0_1_1__1_01__0_1_1_0_0;
    vt[11] = 14'b0_0_1_1_1_0__0_10__0_0_0_0_1;
    vt[12] = 14'b0_0_1_1_1_0__0_10__0_0_0_0_1;
    vt[13] = 14'b0_0_1_1_1_1__0_10__0_0_1_0_1;
    vt[14] = 14'b0_0_1_1_1_1__0_10__0_0_1_0_1;
    vt[15] = 14'b0_0_1_1_1_1__0_10__0_0_1_1_0;
    vt[16] = 14'b0_0_1_1_1_1__0_10__0_0_1_0_1;
    vt[17] = 14'b0_0_1_1_1_1__0_10__0_0_0_0_0;
    for (int i = 0; i < 18; i++) begin
      {req0_val, req1_val, mem_req_rdy, want, resp0_rdy, resp1_rdy} =
        {vt[i].r0v, vt[i].r1v, vt[i].mrdy, vt[i].want, vt[i].p0rdy, vt[i].p1rdy};
      req0_msg = mk_req(8'h10 + 8'(i), 32'h2000 + 32'(i * 16));
      req1_msg = mk_req(8'h80 + 8'(i), 32'h3000 + 32'(i * 16));
      settle();
      check($sformatf("v%0d_mem_req_val", i), 80'(mem_req_val), 80'(vt[i].mrv));
      check($sformatf("v%0d_mem_req_msg", i), 80'(mem_req_msg),
            vt[i].src == 2'd0 ? 80'(req0_msg) : vt[i].src == 2'd1 ? 80'(req1_msg) : 80'(0));
      check($sformatf("v%0d_req0_rdy", i), 80'(req0_rdy), 80'(vt[i].q0rdy));
      check($sformatf("v%0d_req1_rdy", i), 80'(req1_rdy), 80'(vt[i].q1rdy));
      check($sformatf("v%0d_mem_resp_rdy", i), 80'(mem_resp_rdy), 80'(vt[i].mrr));
      check($sformatf("v%0d_resp0_val", i), 80'(resp0_val), 80'(vt[i].s0v));
      check($sformatf("v%0d_resp1_val", i), 80'(resp1_val), 80'(vt[i].s1v));
      commit();
    end
    check("sb_drained", 80'(sb.size()), 80'(0));
    {req0_val, req1_val, mem_req_rdy, want} = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      req0_msg = mk_req(8'h40 + 8'(i), 32'h4000 + 32'(i * 16));
      settle();
      check("mid_req0_rdy", 80'(req0_rdy), 80'(1));
      commit();
    end
    reset = 1'b1;
    req1_val = 1'b1;
    settle();
    check("midrst_req_rdys", 80'({req0_rdy, req1_rdy}), 80'(0));
    check("midrst_mem_req_val", 80'(mem_req_val), 80'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    mem_q.delete();
    want = 1'b1;
    req0_msg = mk_req(8'h50, 32'h5000);
    req1_msg = mk_req(8'h60, 32'h6000);
    settle();
    check("postrst_msg", 80'(mem_req_msg), 80'(req0_msg));
    check("postrst_req_rdys", 80'({req0_rdy, req1_rdy}), 80'(2'b10));
    check("postrst_mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
    commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
